// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle cpu: ALU operation encoding,
// opcode constants and the funct3 -> ALU op mapping used by the decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_I_ALU  = 7'b0010011;

  // R-type and I-type share the funct3 map; only R-type honours the SUB bit.
  function automatic alu_op_e funct3_to_op(input logic [2:0] funct3, input logic sub_sel);
    alu_op_e op;
    case (funct3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b001:  op = ALU_SLL;
      3'b101:  op = ALU_SRL;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] sign_ext12(input logic [11:0] value);
    return {{20{value[11]}}, value};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU; shifts use only the low five bits of operand B.
module alu
  import cpu_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  // Operation select
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/cpu_instruction_memory.sv
// Combinational instruction ROM lookup indexed by word address (PC bits 6:2),
// so fetch wraps every 128 bytes.
module instruction_memory #(
  parameter int ROM_WORDS = 32
) (
  input  logic [31:0] rom [ROM_WORDS],
  input  logic [4:0]  word_addr,
  output logic [31:0] instruction
);

  assign instruction = rom[word_addr];

endmodule

// File: rtl/cpu.sv
// Single-cycle cpu: fetch, decode, register read, execute and write-back in
// one cycle; PC and register file update on the rising clock edge.
module cpu
  import cpu_pkg::*;
#(
  parameter int ROM_WORDS = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] initial_instructions [ROM_WORDS],
  output logic [31:0] pc_out_check,
  output logic [31:0] instruction_check,
  output logic [2:0]  alu_op_check,
  output logic [31:0] register_data_out1_check,
  output logic [31:0] register_data_out2_check,
  output logic [31:0] b_input_check,
  output logic [31:0] register_data_in_check,
  output logic [31:0] alu_result_check,
  output logic        reg_write_check,
  output logic [31:0] imm_ext_check,
  output logic        use_imm_check
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] inst;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rdata1, rdata2, imm_ext, b_input, alu_result;
  alu_op_e     alu_op;
  logic        use_imm, reg_write;

  instruction_memory #(.ROM_WORDS(ROM_WORDS)) u_imem (
    .rom         (initial_instructions),
    .word_addr   (pc_q[6:2]),
    .instruction (inst)
  );

  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign rd      = inst[11:7];
  assign imm_ext = sign_ext12(inst[31:20]);

  // Decoder: unknown opcodes behave as a non-writing ADD
  always_comb begin
    alu_op    = ALU_ADD;
    use_imm   = 1'b0;
    reg_write = 1'b0;
    case (inst[6:0])
      OPCODE_R_TYPE: begin
        alu_op    = funct3_to_op(inst[14:12], inst[30]);
        reg_write = 1'b1;
      end
      OPCODE_I_ALU: begin
        alu_op    = funct3_to_op(inst[14:12], 1'b0);
        use_imm   = 1'b1;
        reg_write = 1'b1;
      end
      default: begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        reg_write = 1'b0;
      end
    endcase
  end

  assign rdata1  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rdata2  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign b_input = use_imm ? imm_ext : rdata2;

  alu u_alu (
    .op     (alu_op),
    .a      (rdata1),
    .b      (b_input),
    .result (alu_result)
  );

  // Next-state for PC and register file (x0 never written)
  always_comb begin
    pc_d   = pc_q + 32'd4;
    regs_d = regs_q;
    if (reg_write && (rd != 5'd0)) begin
      regs_d[rd] = alu_result;
    end else begin
      regs_d = regs_q;
    end
  end

  // State registers; reset loads xi = 3000 + i
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? 32'd0 : 32'(3000 + i);
      end
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

  assign pc_out_check             = pc_q;
  assign instruction_check        = inst;
  assign alu_op_check             = alu_op;
  assign register_data_out1_check = rdata1;
  assign register_data_out2_check = rdata2;
  assign b_input_check            = b_input;
  assign register_data_in_check   = alu_result;
  assign alu_result_check         = alu_result;
  assign reg_write_check          = reg_write;
  assign imm_ext_check            = imm_ext;
  assign use_imm_check            = use_imm;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed sequences, an ALU vector table and a
// randomized program compared against an architectural reference model.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom [32];
  logic [31:0] pc_o, inst_o, out1_o, out2_o, b_o, din_o, res_o, imm_o;
  logic [2:0]  op_o;
  logic        wr_o, ui_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  cpu #(.ROM_WORDS(32), .NUM_REGS(32)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .initial_instructions     (rom),
    .pc_out_check             (pc_o),
    .instruction_check        (inst_o),
    .alu_op_check             (op_o),
    .register_data_out1_check (out1_o),
    .register_data_out2_check (out2_o),
    .b_input_check            (b_o),
    .register_data_in_check   (din_o),
    .alu_result_check         (res_o),
    .reg_write_check          (wr_o),
    .imm_ext_check            (imm_o),
    .use_imm_check            (ui_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference ALU from the arithmetic definitions
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[4:0];
      6: return a >> b[4:0];
      7: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // funct3 -> op number: 000 ADD,001 SLL,010 SLT,011 (none) ADD,100 XOR,101 SRL,110 OR,111 AND
  int f3_map [8] = '{0, 5, 7, 0, 4, 6, 3, 2};

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 32'd0 : 32'(3000 + i);
  endtask

  // Compare every observable against the model, then (if advance) retire the instruction.
  task automatic model_check(input string tag);
    logic [31:0] w, a, r2, imm, b, res;
    int op;
    bit ui, wr;
    w   = rom[(m_pc >> 2) % 32];
    a   = m_regs[w[19:15]];
    r2  = m_regs[w[24:20]];
    imm = {{20{w[31]}}, w[31:20]};
    op = 0; ui = 0; wr = 0;
    if (w[6:0] == 7'h33) begin
      wr = 1;
      op = f3_map[w[14:12]];
      if (w[14:12] == 3'b000 && w[30]) op = 1;
    end else if (w[6:0] == 7'h13) begin
      wr = 1; ui = 1;
      op = f3_map[w[14:12]];
    end
    b   = ui ? imm : r2;
    res = ref_alu(op, a, b);
    chk({tag, " pc"}, pc_o, m_pc);
    chk({tag, " inst"}, inst_o, w);
    chk({tag, " op"}, {29'd0, op_o}, 32'(op));
    chk({tag, " out1"}, out1_o, a);
    chk({tag, " out2"}, out2_o, r2);
    chk({tag, " imm"}, imm_o, imm);
    chk({tag, " b"}, b_o, b);
    chk({tag, " res"}, res_o, res);
    chk({tag, " din"}, din_o, res);
    chk({tag, " wr"}, {31'd0, wr_o}, {31'd0, wr});
    chk({tag, " ui"}, {31'd0, ui_o}, {31'd0, ui});
    if (wr && w[11:7] != 5'd0) m_regs[w[11:7]] = res;
    m_pc = m_pc + 32'd4;
  endtask

  typedef struct {
    logic [2:0]  funct3;
    logic        sub_bit;
    logic [2:0]  exp_op;
    logic [31:0] exp_res;
  } alu_vec_t;

  alu_vec_t vecs [8];

  function automatic logic [31:0] rword(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'd0;

    // ---- Directed: reference program
    rom[0] = 32'h005303b3;  // add x7,x6,x5
    rom[1] = 32'h40848533;  // sub x10,x9,x8
    rom[2] = 32'h00160693;  // addi x13,x12,1
    rom[3] = 32'h00530033;  // add x0,x6,x5
    rom[4] = 32'h006005b3;  // add x11,x0,x6
    rom[5] = 32'h00038633;  // add x12,x7,x0
    reset = 1'b1;
    @(negedge clk);
    chk("rst pc", pc_o, 32'd0);
    reset = 1'b0;
    #1;
    chk("add op", {29'd0, op_o}, 32'd0);
    chk("add out1", out1_o, 32'd3006);
    chk("add out2", out2_o, 32'd3005);
    chk("add res", res_o, 32'd6011);
    chk("add ui", {31'd0, ui_o}, 32'd0);
    step();
    chk("sub pc", pc_o, 32'd4);
    chk("sub op", {29'd0, op_o}, 32'd1);
    chk("sub out1", out1_o, 32'd3009);
    chk("sub out2", out2_o, 32'd3008);
    chk("sub res", res_o, 32'd1);
    step();
    chk("addi pc", pc_o, 32'd8);
    chk("addi ui", {31'd0, ui_o}, 32'd1);
    chk("addi imm", imm_o, 32'd1);
    chk("addi b", b_o, 32'd1);
    chk("addi out1", out1_o, 32'd3012);
    chk("addi res", res_o, 32'd3013);
    step();
    step();
    chk("x0 read", out1_o, 32'd0);
    chk("x0 res", res_o, 32'd3006);
    step();
    chk("x7 written", out1_o, 32'd6011);
    #2 reset = 1'b1;
    #1;
    chk("midrst pc", pc_o, 32'd0);
    rom[0] = 32'h000380b3;  // add x1,x7,x0
    #1;
    chk("midrst x7", out1_o, 32'd3007);

    // ---- ALU table: x1=4, x2=2, then x3 = x1 op x2
    vecs[0] = '{3'b000, 1'b0, 3'd0, 32'd6};
    vecs[1] = '{3'b000, 1'b1, 3'd1, 32'd2};
    vecs[2] = '{3'b111, 1'b0, 3'd2, 32'd0};
    vecs[3] = '{3'b110, 1'b0, 3'd3, 32'd6};
    vecs[4] = '{3'b100, 1'b0, 3'd4, 32'd6};
    vecs[5] = '{3'b001, 1'b0, 3'd5, 32'd16};
    vecs[6] = '{3'b101, 1'b0, 3'd6, 32'd1};
    vecs[7] = '{3'b010, 1'b0, 3'd7, 32'd0};
    for (int i = 0; i < 32; i++) rom[i] = 32'd0;
    rom[0] = 32'h00400093;  // addi x1,x0,4
    rom[1] = 32'h00200113;  // addi x2,x0,2
    for (int i = 0; i < 8; i++)
      rom[2 + i] = rword({1'b0, vecs[i].sub_bit, 5'd0}, 5'd2, 5'd1, vecs[i].funct3, 5'd3, 7'h33);
    rom[10] = 32'hfff00213;  // addi x4,x0,-1
    rom[11] = 32'h00100293;  // addi x5,x0,1
    rom[12] = 32'h00522333;  // slt x6,x4,x5
    @(negedge clk);
    reset = 1'b0;
    #1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("alu%0d op", i), {29'd0, op_o}, {29'd0, vecs[i].exp_op});
      chk($sformatf("alu%0d res", i), res_o, vecs[i].exp_res);
      step();
    end
    step();
    step();
    chk("slt neg", res_o, 32'd1);

    // ---- Randomized program against the model; runs past the 128-byte fetch wrap
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom_range(0, 7));
      if (kind < 5)
        rom[i] = rword({1'b0, (f3 == 3'b000) ? 1'($urandom_range(0, 1)) : 1'b0, 5'd0},
                       5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33);
      else if (kind < 9)
        rom[i] = {12'($urandom), 5'($urandom), f3, 5'($urandom), 7'h13};
      else
        rom[i] = $urandom;
    end
    rom[31] = 32'd0;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int c = 0; c < 150; c++) begin
      model_check($sformatf("rnd%0d", c));
      if (c == 90) begin
        reset = 1'b1;
        #1;
        model_reset();
        chk("rnd midrst pc", pc_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
      end else begin
        step();
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter: ROM_WORDS, 32, number of 32-bit instruction words supplied on initial_instructions.
REQ-002 Parameter: NUM_REGS, 32, number of architectural registers (x0..x31).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: initial_instructions  input  32 x [31:0] (unpacked [31:0])  instruction ROM contents, word i at byte address 4*i.
REQ-006 Port: pc_out_check  output  32  current PC.
REQ-007 Port: instruction_check  output  32  instruction fetched at PC.
REQ-008 Port: alu_op_check  output  3  decoded ALU operation.
REQ-009 Port: register_data_out1_check / register_data_out2_check  output  32 each  register-file reads of rs1 (inst[19:15]) and rs2 (inst[24:20]).
REQ-010 Port: b_input_check  output  32  ALU operand B after immediate mux.
REQ-011 Port: register_data_in_check  output  32  write-back data (equals ALU result).
REQ-012 Port: alu_result_check  output  32  ALU result.
REQ-013 Port: reg_write_check  output  1  register write enable.
REQ-014 Port: imm_ext_check  output  32  sign-extended inst[31:20].
REQ-015 Port: use_imm_check  output  1  1 when operand B is the immediate.

Function
REQ-016 Single-cycle datapath: fetch, decode, read, execute and write-back are combinational within one cycle; PC and register file update on the rising clk edge.
REQ-017 PC SHALL advance by 4 every rising edge when reset is low; 32-bit wrap from 0xFFFFFFFC to 0.
REQ-018 instruction_memory SHALL be combinational: instruction = initial_instructions[pc[6:2]]; pc[1:0] and pc[31:7] are ignored, so fetch wraps every 128 bytes.
REQ-019 R-type (opcode 0110011) SHALL decode funct3/funct7[5]: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL, 010 SLT; use_imm=0, reg_write=1.
REQ-020 I-type ALU (opcode 0010011) SHALL decode funct3: 000 ADDI, 111 ANDI, 110 ORI, 100 XORI, 001 SLLI, 101 SRLI, 010 SLTI; use_imm=1, reg_write=1.
REQ-021 Any other opcode (including all-zero word) SHALL give alu_op=ADD, use_imm=0, reg_write=0; PC still advances.
REQ-022 b_input SHALL be imm_ext when use_imm=1, else rs2 read data.
REQ-023 alu SHALL be combinational, 32-bit: ADD/SUB modulo 2^32; AND/OR/XOR bitwise; SLL/SRL by b[4:0] (logical); SLT = 1 if signed a < signed b, else 0.
REQ-024 Register reads SHALL be combinational; x0 always reads 0 and ignores writes.
REQ-025 On rising edge with reg_write=1 and rd (inst[11:7]) != 0, rd SHALL take alu_result; a read of the same register in that cycle returns the old value.

Reset
REQ-026 While reset is high (asynchronous assertion), PC SHALL be 0 and register xi (i=1..31) SHALL hold 3000+i; reset mid-run restores both immediately.
REQ-027 Outputs have no separate reset value; they follow combinationally from PC=0 and the initialised registers.
REQ-028 The first rising edge after reset deasserts executes the instruction at PC 0 and moves PC to 4.

Structure
REQ-029 A shared package SHALL define the 3-bit ALU op enum, in encoding order ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7, plus the opcode constants.
REQ-030 Sub-modules alu and instruction_memory SHALL be separate modules instantiated by cpu; register file, decoder and immediate sign-extension SHALL be inline.

Verification
REQ-031 ROM[0]=0x005303b3 (add x7,x6,x5), reset pulse -> pc 0, alu_op ADD, out1 3006, out2 3005, result 6011, use_imm 0.
REQ-032 ROM[1]=0x40848533 (sub x10,x9,x8), one edge -> pc 4, alu_op SUB, out1 3009, out2 3008, result 1.
REQ-033 ROM[2]=0x00160693 (addi x13,x12,1), next edge -> pc 8, use_imm 1, imm_ext 1, b_input 1, out1 3012, result 3013.
REQ-034 alu a=4, b=2 -> ADD 6, SUB 2, AND 0, OR 6, XOR 6, SLL 16, SRL 1, SLT 0; a=0xFFFFFFFF, b=1, SLT -> 1.
REQ-035 add x0,x6,x5 then an instruction reading x0 -> x0 reads 0; reset asserted mid-run -> pc 0 and x7 reads 3007 again.
